// File: rtl/defunnel_pkg.sv
// Shared constants and helpers for the defunnel controller: one-hot mode
// encodings, the beat width a mode selects, and the mode legality check.
package defunnel_pkg;

   localparam logic [7:0] DFN_W1 = 8'h01;
   localparam logic [7:0] DFN_W2 = 8'h02;
   localparam logic [7:0] DFN_W4 = 8'h04;

   // Any encoding other than W2/W4 collapses to width 1; legality is checked separately.
   function automatic logic [2:0] dfn_width(input logic [2:0] modeSel);
      case (modeSel)
         3'b010:  return 3'd2;
         3'b100:  return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic dfn_legal(input logic [7:0] modeIn, input int t);
      logic oneHot;
      oneHot = (modeIn[2:0] == 3'b001) || (modeIn[2:0] == 3'b010) || (modeIn[2:0] == 3'b100);
      return oneHot && (modeIn[7:3] == 5'd0) && (int'(dfn_width(modeIn[2:0])) <= t);
   endfunction

endpackage

// File: rtl/defunnel_lane_tracker.sv
// Frame bookkeeping for the defunnel: current lane base, valid lanes and the
// optional closed flag (DEFUNNEL_FLUSH_EN), plus the per-lane write enables.
module defunnel_lane_tracker #(
   parameter int L  = 4,
   parameter int LW = $clog2(L)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          accept_i,
   input  logic [2:0]    width_i,
   input  logic          drain_i,
`ifdef DEFUNNEL_FLUSH_EN
   input  logic          flush_i,
`endif
   output logic [L-1:0]  enable_o,
   output logic [LW-1:0] laneBase_o,
   output logic [L-1:0]  valid_o,
   output logic          full_o
);

   logic [LW-1:0] base_q, base_d;
   logic [L-1:0]  valid_q, valid_d;
   logic [L-1:0]  laneMask;

   // A beat landing in the drain cycle starts the next frame, so it writes from lane 0.
   always_comb begin
      laneMask = '0;
      for (int l = 0; l < L; l++) begin
         laneMask[l] = (l < int'(width_i));
      end
      laneBase_o = drain_i ? '0 : base_q;
      enable_o   = accept_i ? (laneMask << laneBase_o) : '0;
      base_d     = accept_i ? (laneBase_o + LW'(width_i)) : laneBase_o;
      valid_d    = (drain_i ? '0 : valid_q) | enable_o;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q  <= '0;
         valid_q <= '0;
      end else begin
         base_q  <= base_d;
         valid_q <= valid_d;
      end
   end

`ifdef DEFUNNEL_FLUSH_EN
   logic closed_q, closed_d;

   // Flush only closes a frame that holds data and is not already complete.
   always_comb begin
      closed_d = drain_i ? 1'b0 : (closed_q | (flush_i && (|valid_q) && !(&valid_q)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         closed_q <= 1'b0;
      end else begin
         closed_q <= closed_d;
      end
   end

   assign full_o = (&valid_q) | closed_q;
`else
   assign full_o = &valid_q;
`endif

   assign valid_o = valid_q;

endmodule

// File: rtl/defunnel_ctrl_param.sv
// Defunnel controller top: beat handshake, output-word handshake and run-time
// mode configuration. Partial-frame flush is built in with DEFUNNEL_FLUSH_EN.
module defunnel_ctrl_param #(
   parameter int T  = 2,
   parameter int L  = 4,
   parameter int LW = $clog2(L)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [T-1:0]  t_req,
   output logic [T-1:0]  t_ack,
   input  logic          t_cfg_req,
   output logic          t_cfg_ack,
   input  logic [7:0]    mode,
   output logic          cfg_err,
   output logic          i_0_req,
   input  logic          i_0_ack,
   output logic [L-1:0]  enable,
   output logic [LW-1:0] lane_base
`ifdef DEFUNNEL_FLUSH_EN
   ,
   input  logic          flush,
   output logic [L-1:0]  valid_mask
`endif
);
   import defunnel_pkg::*;

   logic [2:0]   mode_q, mode_d;
   logic         cfgErr_q, cfgErr_d;
   logic [2:0]   width;
   logic [T-1:0] reqMask;
   logic         full, room, drain, accept, cfgFire;
   logic [L-1:0] validLanes;

   // Only the active ports take part in a beat; the rest are neither waited on nor acked.
   always_comb begin
      width   = dfn_width(mode_q);
      reqMask = '0;
      for (int j = 0; j < T; j++) begin
         reqMask[j] = (j < int'(width));
      end
      room      = ~full | i_0_ack;
      drain     = full & i_0_ack;
      accept    = ((t_req & reqMask) == reqMask) && room;
      t_ack     = accept ? reqMask : '0;
      t_cfg_ack = ~(|validLanes) && !accept;
      cfgFire   = t_cfg_req && t_cfg_ack;
      mode_d    = (cfgFire && dfn_legal(mode, T)) ? mode[2:0] : mode_q;
      cfgErr_d  = cfgFire && !dfn_legal(mode, T);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q   <= DFN_W1[2:0];
         cfgErr_q <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         cfgErr_q <= cfgErr_d;
      end
   end

   defunnel_lane_tracker #(.L(L), .LW(LW)) uTracker (
      .clk        (clk),
      .reset      (reset),
      .accept_i   (accept),
      .width_i    (width),
      .drain_i    (drain),
`ifdef DEFUNNEL_FLUSH_EN
      .flush_i    (flush),
`endif
      .enable_o   (enable),
      .laneBase_o (lane_base),
      .valid_o    (validLanes),
      .full_o     (full)
   );

   assign i_0_req = full;
   assign cfg_err = cfgErr_q;
`ifdef DEFUNNEL_FLUSH_EN
   assign valid_mask = validLanes;
`endif

endmodule

// File: tb/tb_defunnel_ctrl_param.sv
// Self-checking bench for defunnel_ctrl_param (T=2, L=4): directed steps then
// random traffic against a lane-count model. Flush checks need DEFUNNEL_FLUSH_EN.
module tb_defunnel_ctrl_param;

   localparam int T  = 2;
   localparam int L  = 4;
   localparam int LW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [T-1:0]  t_req;
   logic [T-1:0]  t_ack;
   logic          t_cfg_req;
   logic          t_cfg_ack;
   logic [7:0]    mode;
   logic          cfg_err;
   logic          i_0_req;
   logic          i_0_ack;
   logic [L-1:0]  enable;
   logic [LW-1:0] lane_base;
   logic          flushDrv;
`ifdef DEFUNNEL_FLUSH_EN
   logic [L-1:0]  valid_mask;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Reference model: lanes filled so far, closed flag, active width, pending error pulse.
   int mFilled = 0;
   int mW = 1;
   bit mClosed = 1'b0;
   bit mErr = 1'b0;

   logic [7:0] modeTab [6] = '{8'h01, 8'h02, 8'h04, 8'h03, 8'h00, 8'h82};

   defunnel_ctrl_param #(.T(T), .L(L), .LW(LW)) dut (
      .clk        (clk),
      .reset      (reset),
      .t_req      (t_req),
      .t_ack      (t_ack),
      .t_cfg_req  (t_cfg_req),
      .t_cfg_ack  (t_cfg_ack),
      .mode       (mode),
      .cfg_err    (cfg_err),
      .i_0_req    (i_0_req),
      .i_0_ack    (i_0_ack),
      .enable     (enable),
      .lane_base  (lane_base)
`ifdef DEFUNNEL_FLUSH_EN
      ,
      .flush      (flushDrv),
      .valid_mask (valid_mask)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [T-1:0] r, input logic cr, input logic [7:0] m,
                                input logic a, input logic f);
      t_req     = r;
      t_cfg_req = cr;
      mode      = m;
      i_0_ack   = a;
      flushDrv  = f;
   endtask

   task automatic modelReset();
      mFilled = 0;
      mW      = 1;
      mClosed = 1'b0;
      mErr    = 1'b0;
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      bit full, drain, room, allReq, acc, cfgAck, legal, flushEff, nClosed;
      int baseEff, nFilled, mv;
      #4;
      full   = (mFilled == L) || mClosed;
      drain  = full && i_0_ack;
      room   = !full || i_0_ack;
      allReq = 1'b1;
      for (int j = 0; j < mW; j++) begin
         if (!t_req[j]) allReq = 1'b0;
      end
      acc     = allReq && room;
      baseEff = drain ? 0 : (mFilled % L);
      cfgAck  = (mFilled == 0) && !acc;
      checkOutput("t_ack",     32'(t_ack),     acc ? ((1 << mW) - 1) : 0);
      checkOutput("enable",    32'(enable),    acc ? (((1 << mW) - 1) << baseEff) : 0);
      checkOutput("lane_base", 32'(lane_base), baseEff);
      checkOutput("i_0_req",   32'(i_0_req),   32'(full));
      checkOutput("t_cfg_ack", 32'(t_cfg_ack), 32'(cfgAck));
      checkOutput("cfg_err",   32'(cfg_err),   32'(mErr));
`ifdef DEFUNNEL_FLUSH_EN
      checkOutput("valid_mask", 32'(valid_mask), (1 << mFilled) - 1);
      flushEff = flushDrv;
`else
      flushEff = 1'b0;
`endif
      @(posedge clk);
      if (reset) begin
         modelReset();
      end else begin
         nFilled = drain ? 0 : mFilled;
         if (acc) nFilled += mW;
         nClosed = drain ? 1'b0 : mClosed;
         if (flushEff && mFilled != 0 && !full) nClosed = 1'b1;
         mv    = int'(mode);
         legal = (mv == 1 || mv == 2 || mv == 4) && (mv <= T);
         mErr  = 1'b0;
         if (t_cfg_req && cfgAck) begin
            if (legal) mW = mv;
            else       mErr = 1'b1;
         end
         mFilled = nFilled;
         mClosed = nClosed;
      end
      #1;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus('0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      cycle();
      reset = 1'b0;

      // w=1, port 0 held: four beats fill the frame, then the port stalls.
      applyStimulus(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (6) cycle();
      checkOutput("frameReady", 32'(i_0_req), 32'd1);

      // Drain and refill at full rate, then empty the last frame.
      applyStimulus(2'b01, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (8) cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle();

      // Mode 0x02 requested mid-frame stalls until the frame drains.
      applyStimulus(2'b01, 1'b1, 8'h02, 1'b0, 1'b0);
      repeat (4) cycle();
      applyStimulus(2'b00, 1'b1, 8'h02, 1'b1, 1'b0);
      cycle();
      applyStimulus(2'b00, 1'b1, 8'h02, 1'b0, 1'b0);
      cycle();
      applyStimulus(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) cycle();
      applyStimulus(2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      checkOutput("w2Enable", 32'(enable), 32'h3);
      checkOutput("w2Ack", 32'(t_ack), 32'h3);
      repeat (2) cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle();

      // Width 4 exceeds T=2 and reserved bits are set: both rejected.
      applyStimulus(2'b00, 1'b1, 8'h04, 1'b0, 1'b0);
      cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("cfgErrPulse", 32'(cfg_err), 32'd1);
      cycle();
      applyStimulus(2'b00, 1'b1, 8'h82, 1'b0, 1'b0);
      cycle();
      applyStimulus(2'b11, 1'b1, 8'h01, 1'b0, 1'b0);
      cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      applyStimulus(2'b00, 1'b1, 8'h01, 1'b0, 1'b0);
      cycle();

      // Asynchronous reset after two beats discards the frame at once.
      applyStimulus(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("rstLaneBase", 32'(lane_base), 32'd0);
      checkOutput("rstReq", 32'(i_0_req), 32'd0);
      checkOutput("rstCfgAck", 32'(t_cfg_ack), 32'd1);
      cycle();
      reset = 1'b0;

`ifdef DEFUNNEL_FLUSH_EN
      // A single beat flushed out as a partial word, then the next frame starts at lane 0.
      applyStimulus(2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("flushMask", 32'(valid_mask), 32'h1);
      cycle();
      applyStimulus(2'b01, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      applyStimulus(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
`endif

      for (int i = 0; i < 400; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                       modeTab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
